// File: rtl/load_store_unit_if.sv
// CPU request/response and memory-port signals of the load/store unit, grouped for one port connection.
// The slave modport is the LSU view; master is the CPU/memory side.
interface load_store_unit_if;
   logic        iReq;
   logic        iWrite;
   logic [1:0]  iSize;
   logic        iSigned;
   logic [63:0] iAddress;
   logic [63:0] iStoreData;
   logic        oBusy;
   logic        oDone;
   logic        oFault;
   logic [63:0] oLoadData;
   logic [63:0] oMemAddress;
   logic [63:0] oMemWriteData;
   logic        oMemRead;
   logic        oMemWrite;
   logic [63:0] iMemData;

   modport slave (
      input  iReq, iWrite, iSize, iSigned, iAddress, iStoreData, iMemData,
      output oBusy, oDone, oFault, oLoadData, oMemAddress, oMemWriteData, oMemRead, oMemWrite
   );

   modport master (
      output iReq, iWrite, iSize, iSigned, iAddress, iStoreData, iMemData,
      input  oBusy, oDone, oFault, oLoadData, oMemAddress, oMemWriteData, oMemRead, oMemWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit over a 64-bit word memory; sub-doubleword stores run as read-modify-write.
// Define LSU_SIGN_EXT_EN to honour iSigned on byte/half/word loads (otherwise all loads zero-extend).
module load_store_unit (
   input  logic             iCLK,
   input  logic             iRST,
   load_store_unit_if.slave lsu
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [63:0] ADDR_LIMIT = 64'h4800;

   state_t      state_q, state_d;
   logic        write_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q;
   logic [63:0] sdata_q;
   logic [63:0] wdata_q;
   logic [63:0] load_q;
   logic        fault_q;

   logic        accept;
   logic        req_fault;
   logic [5:0]  lane_shift;
   logic [63:0] mask;
   logic [63:0] lane;
   logic [63:0] load_ext;
   logic [63:0] merged;

`ifdef LSU_SIGN_EXT_EN
   logic        signed_q;
`else
   logic        unused_signed;
   assign unused_signed = lsu.iSigned;
`endif

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] m;
      case (size)
         2'b00:   m = 64'h0000_0000_0000_00FF;
         2'b01:   m = 64'h0000_0000_0000_FFFF;
         2'b10:   m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = low[0];
         2'b10:   bad = |low[1:0];
         default: bad = |low;
      endcase
      return bad;
   endfunction

   assign accept    = (state_q == S_IDLE) && lsu.iReq;
   assign req_fault = misaligned(lsu.iSize, lsu.iAddress[2:0]) || (lsu.iAddress >= ADDR_LIMIT);

   // Lane datapath: the addressed bytes of the memory word, little-endian.
   assign lane_shift = {addr_q[2:0], 3'b000};
   assign mask       = size_mask(size_q);
   assign lane       = (lsu.iMemData >> lane_shift) & mask;
   assign merged     = (lsu.iMemData & ~(mask << lane_shift)) | ((sdata_q & mask) << lane_shift);

   always_comb begin
      load_ext = lane;
`ifdef LSU_SIGN_EXT_EN
      if (signed_q) begin
         case (size_q)
            2'b00:   load_ext = {{56{lane[7]}},  lane[7:0]};
            2'b01:   load_ext = {{48{lane[15]}}, lane[15:0]};
            2'b10:   load_ext = {{32{lane[31]}}, lane[31:0]};
            default: load_ext = lane;
         endcase
      end
`endif
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_IDLE;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         sdata_q <= '0;
         wdata_q <= '0;
         load_q  <= '0;
         fault_q <= 1'b0;
`ifdef LSU_SIGN_EXT_EN
         signed_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            write_q <= lsu.iWrite;
            size_q  <= lsu.iSize;
            addr_q  <= lsu.iAddress;
            sdata_q <= lsu.iStoreData;
            wdata_q <= lsu.iStoreData;
            fault_q <= req_fault;
`ifdef LSU_SIGN_EXT_EN
            signed_q <= lsu.iSigned;
`endif
         end
         if (state_q == S_CAP) begin
            if (write_q) begin
               wdata_q <= merged;
            end else begin
               load_q <= load_ext;
            end
         end
      end
   end

   always_comb begin
      state_d           = state_q;
      lsu.oBusy         = 1'b1;
      lsu.oDone         = 1'b0;
      lsu.oMemRead      = 1'b0;
      lsu.oMemWrite     = 1'b0;
      lsu.oMemAddress   = '0;
      lsu.oMemWriteData = '0;
      case (state_q)
         S_IDLE: begin
            lsu.oBusy = 1'b0;
            if (lsu.iReq) begin
               if (req_fault) begin
                  state_d = S_DONE;
               end else if (lsu.iWrite && (lsu.iSize == 2'b11)) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            lsu.oMemRead    = 1'b1;
            lsu.oMemAddress = {addr_q[63:3], 3'b000};
            state_d         = S_CAP;
         end
         S_CAP: begin
            state_d = write_q ? S_WR : S_DONE;
         end
         S_WR: begin
            lsu.oMemWrite     = 1'b1;
            lsu.oMemAddress   = {addr_q[63:3], 3'b000};
            lsu.oMemWriteData = wdata_q;
            state_d           = S_DONE;
         end
         S_DONE: begin
            lsu.oDone = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            lsu.oBusy = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   assign lsu.oFault    = fault_q;
   assign lsu.oLoadData = load_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;
   logic iCLK = 1'b0;
   logic iRST;

   load_store_unit_if bus();
   load_store_unit dut (.iCLK(iCLK), .iRST(iRST), .lsu(bus));

   always #5 iCLK = ~iCLK;

`ifdef LSU_SIGN_EXT_EN
   localparam bit SIGN_EXT = 1'b1;
`else
   localparam bit SIGN_EXT = 1'b0;
`endif

   logic [63:0] mem     [0:4095];
   logic [63:0] ref_mem [0:4095];
   int checks = 0;
   int errors = 0;

   // Memory responds with read data one cycle after the read strobe.
   always @(posedge iCLK) begin
      if (bus.oMemRead)  bus.iMemData <= mem[bus.oMemAddress[14:3]];
      if (bus.oMemWrite) mem[bus.oMemAddress[14:3]] <= bus.oMemWriteData;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_fault(input logic [1:0] size, input logic [63:0] addr);
      logic [63:0] n;
      n = 64'd1 << size;
      return ((addr % n) != 64'd0) || (addr >= 64'h4800);
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] word, input logic [2:0] off,
                                              input logic [1:0] size, input logic sgn);
      int n;
      logic [63:0] v;
      n = 1 << size;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
      if (SIGN_EXT && sgn && n < 8 && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                            input logic [63:0] addr, input logic [63:0] data);
      bus.iReq       = 1'b1;
      bus.iWrite     = wr;
      bus.iSize      = size;
      bus.iSigned    = sgn;
      bus.iAddress   = addr;
      bus.iStoreData = data;
   endtask

   task automatic access(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] data);
      logic flt;
      int n, idx, exp_lat, exp_rd, exp_wr, lat, rd, wrc, aerr;
      logic [63:0] exp_load, word;
      flt      = model_fault(size, addr);
      n        = 1 << size;
      idx      = int'(addr[14:3]);
      exp_lat  = flt ? 1 : (wr ? ((n == 8) ? 2 : 4) : 3);
      exp_rd   = (!flt && !(wr && n == 8)) ? 1 : 0;
      exp_wr   = (!flt && wr) ? 1 : 0;
      exp_load = '0;
      if (!flt) begin
         exp_load = model_load(ref_mem[idx], addr[2:0], size, sgn);
         if (wr) begin
            word = ref_mem[idx];
            for (int i = 0; i < n; i++) word[8*(int'(addr[2:0]) + i) +: 8] = data[8*i +: 8];
            ref_mem[idx] = word;
         end
      end
      @(negedge iCLK);
      drive_req(wr, size, sgn, addr, data);
      @(posedge iCLK);
      lat = 0; rd = 0; wrc = 0; aerr = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge iCLK);
         if (k == 1) bus.iReq = 1'b0;
         if (bus.oMemRead)  rd++;
         if (bus.oMemWrite) wrc++;
         if ((bus.oMemRead || bus.oMemWrite) && bus.oMemAddress !== {addr[63:3], 3'b000}) aerr++;
         if (bus.oDone) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " fault"}, 64'(bus.oFault), 64'(flt));
      check({tag, " reads"}, 64'(rd), 64'(exp_rd));
      check({tag, " writes"}, 64'(wrc), 64'(exp_wr));
      check({tag, " memaddr_errs"}, 64'(aerr), 64'd0);
      if (!flt && !wr) check({tag, " loaddata"}, bus.oLoadData, exp_load);
      if (!flt && wr)  check({tag, " memword"}, mem[idx], ref_mem[idx]);
      @(negedge iCLK);
      check({tag, " done_pulse"}, 64'(bus.oDone), 64'd0);
      check({tag, " idle"}, 64'(bus.oBusy), 64'd0);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [63:0] a, d;
      logic        w, s;
      int          r, wseen;
      logic [9:0]  done_vec, busy_vec;

      for (int i = 0; i < 4096; i++) begin
         mem[i]     = {$urandom, $urandom};
         ref_mem[i] = mem[i];
      end
      mem[2]     = 64'h8877665544332211;
      ref_mem[2] = 64'h8877665544332211;

      // Reset with a request pending: it must be ignored.
      iRST = 1'b1;
      drive_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
      repeat (3) @(negedge iCLK);
      bus.iReq = 1'b0;
      iRST     = 1'b0;
      check("rst busy", 64'(bus.oBusy), 64'd0);
      check("rst done", 64'(bus.oDone), 64'd0);
      check("rst fault", 64'(bus.oFault), 64'd0);
      check("rst loaddata", bus.oLoadData, 64'd0);
      check("rst memaddr", bus.oMemAddress, 64'd0);
      check("rst memwdata", bus.oMemWriteData, 64'd0);
      check("rst memread", 64'(bus.oMemRead), 64'd0);
      check("rst memwrite", 64'(bus.oMemWrite), 64'd0);

      access("ld_dword_0x10", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
      check("ld_dword_0x10 const", bus.oLoadData, 64'h8877665544332211);
      access("ld_byte_0x17", 1'b0, 2'b00, 1'b1, 64'h17, 64'h0);
      check("ld_byte_0x17 const", bus.oLoadData, SIGN_EXT ? 64'hFFFFFFFFFFFFFF88 : 64'h88);
      access("st_half_0x12", 1'b1, 2'b01, 1'b0, 64'h12, 64'hBEEF);
      check("st_half_0x12 const", mem[2], 64'h88776655BEEF2211);
      access("ld_word_0x6", 1'b0, 2'b10, 1'b0, 64'h6, 64'h0);
      access("st_dword_0x4800", 1'b1, 2'b11, 1'b0, 64'h4800, 64'h1234);
      access("ld_half_signed", 1'b0, 2'b01, 1'b1, 64'h16, 64'h0);

      // Reset during CAP of a byte store abandons the write.
      @(negedge iCLK);
      drive_req(1'b1, 2'b00, 1'b0, 64'h13, 64'h5A);
      @(posedge iCLK);
      @(negedge iCLK);
      bus.iReq = 1'b0;
      check("rmw_rst rd", 64'(bus.oMemRead), 64'd1);
      @(negedge iCLK);
      check("rmw_rst cap busy", 64'(bus.oBusy), 64'd1);
      iRST  = 1'b1;
      wseen = 0;
      @(negedge iCLK);
      iRST = 1'b0;
      if (bus.oMemWrite) wseen++;
      check("rmw_rst busy", 64'(bus.oBusy), 64'd0);
      check("rmw_rst done", 64'(bus.oDone), 64'd0);
      check("rmw_rst fault", 64'(bus.oFault), 64'd0);
      check("rmw_rst loaddata", bus.oLoadData, 64'd0);
      check("rmw_rst memaddr", bus.oMemAddress, 64'd0);
      check("rmw_rst memwdata", bus.oMemWriteData, 64'd0);
      check("rmw_rst memread", 64'(bus.oMemRead), 64'd0);
      repeat (3) begin
         @(negedge iCLK);
         if (bus.oMemWrite) wseen++;
      end
      check("rmw_rst writes", 64'(wseen), 64'd0);
      check("rmw_rst memword", mem[2], ref_mem[2]);

      // Request held high across two loads.
      @(negedge iCLK);
      drive_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
      @(posedge iCLK);
      done_vec = '0;
      busy_vec = '0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge iCLK);
         done_vec[k] = bus.oDone;
         busy_vec[k] = bus.oBusy;
         if (k == 5) bus.iReq = 1'b0;
      end
      check("b2b done_pattern", 64'(done_vec), 64'h088);
      check("b2b busy_pattern", 64'(busy_vec), 64'h0EE);
      check("b2b loaddata", bus.oLoadData, ref_mem[2]);

      for (int t = 0; t < 120; t++) begin
         sz = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         d  = {$urandom, $urandom};
         r  = int'($urandom_range(0, 9));
         a  = (r < 5) ? 64'($urandom_range(0, 32'hFF)) : 64'($urandom_range(0, 32'h47FF));
         if (r == 7)      a = 64'h4800 + 64'($urandom_range(0, 32'hFF));
         else if (r == 8) a = {32'($urandom) | 32'h1, a[31:0]};
         else if (r != 9) a = a & ~((64'd1 << sz) - 64'd1);
         access($sformatf("rand%0d", t), w, sz, s, a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
